// File: rtl/fp_pkg.sv
// Shared single-precision FP definitions: field slices, unpacked operand struct, unpack helper.
// Used by the align stage and by the normalizer/rounder.
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_W     = 1 + FP_EXP_W + FP_MAN_W;

    localparam int SIGN_BIT = FP_EXP_W + FP_MAN_W;
    localparam int EXP_MSB  = SIGN_BIT - 1;
    localparam int EXP_LSB  = FP_MAN_W;
    localparam int FRAC_MSB = FP_MAN_W - 1;

    // Alignment shift amount is carried in 5 bits and saturates at 31.
    localparam int DIFF_W = 5;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] eff_exp;
        logic [FP_MAN_W:0]   sig;
    } fp_unpacked_t;

    // Subnormals (exp field 0) get hidden bit 0 and effective exponent 1.
    function automatic fp_unpacked_t fp_unpack(input logic [FP_W-1:0] x);
        fp_unpacked_t u;
        logic [FP_EXP_W-1:0] e;
        e         = x[EXP_MSB:EXP_LSB];
        u.sign    = x[SIGN_BIT];
        u.eff_exp = (e == '0) ? FP_EXP_W'(1) : e;
        u.sig     = {(e != '0), x[FRAC_MSB:0]};
        return u;
    endfunction

endpackage

// File: rtl/fp_sticky_rshift.sv
// Combinational logical right shift returning the shifted word and the OR of every bit shifted out.
// Shift amounts at or beyond W give a zero result with sticky = OR of the whole input.
module fp_sticky_rshift #(
    parameter int W    = 26,
    parameter int SH_W = 5
) (
    input  logic [W-1:0]    i_dat,
    input  logic [SH_W-1:0] i_shamt,
    output logic [W-1:0]    o_dat,
    output logic            o_sticky
);

    logic [W-1:0] w_mask;

    assign o_dat    = i_dat >> i_shamt;
    // Mask covers the bits that fall off the bottom; all ones once the shift reaches W.
    assign w_mask   = ~({W{1'b1}} << i_shamt);
    assign o_sticky = |(i_dat & w_mask);

endmodule

// File: rtl/fp_align_unit.sv
// Two-stage pre-add aligner: s1 unpacks, orders by magnitude and forms the exponent gap; s2 shifts the
// smaller significand with guard/round/sticky. Valid/ready on both sides, 1 pair/cycle, 2-cycle latency.
module fp_align_unit
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W-1:0]       out_exp,
    output logic [MAN_W:0]         out_mant_big,
    output logic [MAN_W+2:0]       out_mant_small,
    output logic                   out_sticky,
    output logic                   out_sign_big,
    output logic                   out_eff_sub,
    output logic                   out_special
);

    localparam logic [DIFF_W-1:0] DIFF_SAT = '1;

    fp_unpacked_t         w_ua, w_ub, w_big, w_small;
    logic                 w_a_big;
    logic [EXP_W-1:0]     w_exp_diff;
    logic [DIFF_W-1:0]    w_diff;
    logic                 w_special;

    logic                 r_s1_vld;
    fp_unpacked_t         r_s1_big;
    logic [MAN_W:0]       r_s1_small_sig;
    logic [DIFF_W-1:0]    r_s1_diff;
    logic                 r_s1_eff_sub;
    logic                 r_s1_special;

    logic                 r_s2_vld;
    logic [EXP_W-1:0]     r_exp;
    logic [MAN_W:0]       r_mant_big;
    logic [MAN_W+2:0]     r_mant_small;
    logic                 r_sticky;
    logic                 r_sign_big;
    logic                 r_eff_sub;
    logic                 r_special;

    logic                 w_s2_accept;
    logic                 w_s1_advance;
    logic                 w_in_fire;
    logic [MAN_W+2:0]     w_shifted;
    logic                 w_sticky;

    assign w_ua       = fp_unpack(in_a);
    assign w_ub       = fp_unpack(in_b);
    // Exact magnitude tie keeps A as the big operand.
    assign w_a_big    = {w_ua.eff_exp, w_ua.sig} >= {w_ub.eff_exp, w_ub.sig};
    assign w_big      = w_a_big ? w_ua : w_ub;
    assign w_small    = w_a_big ? w_ub : w_ua;
    assign w_exp_diff = w_big.eff_exp - w_small.eff_exp;
    assign w_diff     = (w_exp_diff > EXP_W'(DIFF_SAT)) ? DIFF_SAT : w_exp_diff[DIFF_W-1:0];
    assign w_special  = (&in_a[EXP_MSB:EXP_LSB]) | (&in_b[EXP_MSB:EXP_LSB]);

    assign w_s2_accept  = !r_s2_vld || out_ready;
    assign w_s1_advance = r_s1_vld && w_s2_accept;
    assign in_ready     = !r_s1_vld || w_s1_advance;
    assign w_in_fire    = in_valid && in_ready;

    fp_sticky_rshift #(
        .W    (MAN_W + 3),
        .SH_W (DIFF_W)
    ) u_shift (
        .i_dat    ({r_s1_small_sig, 2'b00}),
        .i_shamt  (r_s1_diff),
        .o_dat    (w_shifted),
        .o_sticky (w_sticky)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld       <= 1'b0;
            r_s1_big       <= '0;
            r_s1_small_sig <= '0;
            r_s1_diff      <= '0;
            r_s1_eff_sub   <= 1'b0;
            r_s1_special   <= 1'b0;
        end else begin
            r_s1_vld <= w_in_fire || (r_s1_vld && !w_s1_advance);
            if (w_in_fire) begin
                r_s1_big       <= w_big;
                r_s1_small_sig <= w_small.sig;
                r_s1_diff      <= w_diff;
                r_s1_eff_sub   <= w_ua.sign ^ w_ub.sign;
                r_s1_special   <= w_special;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld     <= 1'b0;
            r_exp        <= '0;
            r_mant_big   <= '0;
            r_mant_small <= '0;
            r_sticky     <= 1'b0;
            r_sign_big   <= 1'b0;
            r_eff_sub    <= 1'b0;
            r_special    <= 1'b0;
        end else if (w_s2_accept) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_exp        <= r_s1_big.eff_exp;
                r_mant_big   <= r_s1_big.sig;
                r_mant_small <= w_shifted;
                r_sticky     <= w_sticky;
                r_sign_big   <= r_s1_big.sign;
                r_eff_sub    <= r_s1_eff_sub;
                r_special    <= r_s1_special;
            end
        end
    end

    assign out_valid      = r_s2_vld;
    assign out_exp        = r_exp;
    assign out_mant_big   = r_mant_big;
    assign out_mant_small = r_mant_small;
    assign out_sticky     = r_sticky;
    assign out_sign_big   = r_sign_big;
    assign out_eff_sub    = r_eff_sub;
    assign out_special    = r_special;

endmodule

// File: tb/tb_fp_align_unit.sv
// Bench for fp_align_unit: table vectors, random stream with random backpressure, latency,
// full-pipeline stall and mid-flight reset sequences, all scored through an expected-result queue.
module tb_fp_align_unit;

    typedef struct packed {
        logic [7:0]  e;
        logic [23:0] mb;
        logic [25:0] ms;
        logic        st;
        logic        sgn;
        logic        sub;
        logic        spc;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        res_t        r;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_exp;
    logic [23:0] out_mant_big;
    logic [25:0] out_mant_small;
    logic        out_sticky;
    logic        out_sign_big;
    logic        out_eff_sub;
    logic        out_special;

    res_t act;
    assign act = {out_exp, out_mant_big, out_mant_small, out_sticky, out_sign_big, out_eff_sub, out_special};

    int   errors = 0;
    int   checks = 0;
    int   accepted = 0;
    res_t exp_q[$];
    logic stall = 1'b0;
    res_t held;

    fp_align_unit #(.EXP_W(8), .MAN_W(23)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_exp        (out_exp),
        .out_mant_big   (out_mant_big),
        .out_mant_small (out_mant_small),
        .out_sticky     (out_sticky),
        .out_sign_big   (out_sign_big),
        .out_eff_sub    (out_eff_sub),
        .out_special    (out_special)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic res_t mk(input logic [7:0] e, input logic [23:0] mb, input logic [25:0] ms,
                                input logic st, input logic sgn, input logic sub, input logic spc);
        return {e, mb, ms, st, sgn, sub, spc};
    endfunction

    // Bit-serial reference: each bit of the extended small significand either lands in the
    // result at position i-d or, if it falls below bit 0, feeds sticky.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  ea, eb;
        logic [23:0] sa, sbg;
        logic [23:0] s_sm;
        logic [25:0] ext;
        logic        a_big;
        int          d;
        res_t        r;
        ea    = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
        eb    = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
        sa    = {a[30:23] != 8'd0, a[22:0]};
        sbg   = {b[30:23] != 8'd0, b[22:0]};
        a_big = (ea > eb) || ((ea == eb) && (sa >= sbg));
        r     = '0;
        r.e   = a_big ? ea : eb;
        r.mb  = a_big ? sa : sbg;
        s_sm  = a_big ? sbg : sa;
        d     = a_big ? (int'(ea) - int'(eb)) : (int'(eb) - int'(ea));
        if (d > 31) d = 31;
        ext = {s_sm, 2'b00};
        for (int i = 0; i < 26; i++) begin
            if (i < d) r.st = r.st | ext[i];
            else       r.ms[i-d] = ext[i];
        end
        r.sgn = a_big ? a[31] : b[31];
        r.sub = a[31] ^ b[31];
        r.spc = (&a[30:23]) | (&b[30:23]);
        return r;
    endfunction

    // Output monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                checks++;
                if (!out_valid || act !== held) begin
                    errors++;
                    $display("FAIL hold: out_valid=%b data=%h, required valid=1 data=%h", out_valid, act, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %h, required no output", act);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL result: got %h, required %h", act, e);
                    end
                end
            end
            stall = out_valid && !out_ready;
            held  = act;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input res_t r);
        int n;
        n        = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b, required 1 within 200 cycles", in_ready);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(r);
            accepted++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    vec_t tbl[12];
    logic [31:0] ra, rb;
    logic        rnd_bp;
    logic        seen;

    initial begin
        tbl[0]  = '{32'h3F800000, 32'h3F000000, mk(8'd127, 24'h800000, 26'h1000000, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[1]  = '{32'h3F000000, 32'h3F800000, mk(8'd127, 24'h800000, 26'h1000000, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[2]  = '{32'hBF800000, 32'h3FC00000, mk(8'd127, 24'hC00000, 26'h2000000, 1'b0, 1'b0, 1'b1, 1'b0)};
        tbl[3]  = '{32'h3F800000, 32'h33800001, mk(8'd127, 24'h800000, 26'h0000002, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[4]  = '{32'h3F800000, 32'h32800000, mk(8'd127, 24'h800000, 26'h0000000, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[5]  = '{32'h00800000, 32'h00000001, mk(8'd1,   24'h800000, 26'h0000004, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[6]  = '{32'h3F800000, 32'h33000000, mk(8'd127, 24'h800000, 26'h0000001, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[7]  = '{32'h3F800000, 32'h3E000001, mk(8'd127, 24'h800000, 26'h0400000, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[8]  = '{32'h00000000, 32'h00000000, mk(8'd1,   24'h000000, 26'h0000000, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[9]  = '{32'h80000000, 32'h00000000, mk(8'd1,   24'h000000, 26'h0000000, 1'b0, 1'b1, 1'b1, 1'b0)};
        tbl[10] = '{32'h7F800000, 32'h3F800000, mk(8'd255, 24'h800000, 26'h0000000, 1'b1, 1'b0, 1'b0, 1'b1)};
        tbl[11] = '{32'h40400000, 32'hC0400000, mk(8'd128, 24'hC00000, 26'h3000000, 1'b0, 1'b0, 1'b1, 1'b0)};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        rnd_bp    = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {2'b0, act}, 64'd0);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single pair into an empty pipe: out_valid appears two cycles after accept.
        in_a = 32'h3F800000;
        in_b = 32'h3F000000;
        in_valid = 1'b1;
        @(negedge clk);
        chk("lat_in_ready", {63'd0, in_ready}, 64'd1);
        exp_q.push_back(tbl[0].r);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", {63'd0, out_valid}, 64'd1);
        drain();

        foreach (tbl[i]) send(tbl[i].a, tbl[i].b, tbl[i].r);
        in_valid = 1'b0;
        drain();

        // Random stream with random output stalls.
        rnd_bp = 1'b1;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    ra = $urandom;
                    rb = $urandom;
                    if ($urandom_range(0, 3) != 0)
                        rb[30:23] = ra[30:23] + 8'($urandom_range(0, 30)) - 8'd15;
                    send(ra, rb, model(ra, rb));
                end
                in_valid = 1'b0;
                rnd_bp   = 1'b0;
            end
            begin
                while (rnd_bp) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Four back-to-back pairs against a stalled output: only two fit.
        out_ready = 1'b0;
        accepted  = 0;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    ra = 32'h3F800000 + 32'(k);
                    rb = 32'h3E000000 + 32'(k * 7);
                    send(ra, rb, model(ra, rb));
                end
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                chk("bp_accepted", 64'(accepted), 64'd2);
                chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_total_accepted", 64'(accepted), 64'd4);

        // Two pairs in flight, then an asynchronous reset between edges.
        out_ready = 1'b0;
        send(32'h3F800000, 32'h3F000000, tbl[0].r);
        send(32'hBF800000, 32'h3FC00000, tbl[2].r);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_outputs", {2'b0, act}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("no_stale_output", {63'd0, seen}, 64'd0);

        // Pipeline still works after the reset.
        @(posedge clk);
        #1;
        send(tbl[5].a, tbl[5].b, tbl[5].r);
        in_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
